// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//
// Fetch-side handshake into the IF/ID instruction queue.
//
// Signals:
//   in_valid        fetch presents PC_in / Instruction_in this cycle
//   PC_in           fetched PC
//   Instruction_in  fetched instruction
//   in_ready        queue can accept this cycle (combinational from the queue)
//
// Modports:
//   master  fetch stage: drives the request, observes in_ready
//   slave   fetch_queue: observes the request, drives in_ready
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic [PC_W-1:0]    PC_in;
    logic [INSTR_W-1:0] Instruction_in;
    logic               in_ready;

    modport master (
        output in_valid,
        output PC_in,
        output Instruction_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  PC_in,
        input  Instruction_in,
        output in_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// IF/ID boundary buffer. A DEPTH-entry in-order circular queue of
// {PC, Instruction} sits between fetch and a registered decode-stage output.
// Fetch keeps filling the queue while decode is frozen; a flush drops all
// queued and in-flight instructions and presents a NOP bubble to decode.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   freeze       decode stall: output register and head are held
//   flush        discard queue and this cycle's input, present NOP bubble
//   fetch        fetch_queue_if.slave (in_valid, PC_in, Instruction_in, in_ready)
//   PC           decode-stage PC (registered)
//   Instruction  decode-stage instruction (registered)
//   out_valid    PC/Instruction hold a real instruction
//   count        queued entries, not counting the output register
//
// DEPTH must be a power of two and at least 2 so the pointers wrap simply by
// overflowing their $clog2(DEPTH) bits.
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter int                 DEPTH     = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {4'b1110, {(INSTR_W-4){1'b0}}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         freeze,
    input  logic                         flush,
    fetch_queue_if.slave                 fetch,
    output logic [PC_W-1:0]              PC,
    output logic [INSTR_W-1:0]           Instruction,
    output logic                         out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]   head_q,  head_d;
    logic [PTR_W-1:0]   tail_q,  tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PC_W-1:0]    pc_q,    pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    // Queue storage. Contents are never cleared; only the pointers are, so
    // a stale entry can never be read because count gates every pop.
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    // ------------------------------------------------------------------
    // Handshake and datapath control
    // ------------------------------------------------------------------
    logic queue_full;
    logic queue_empty;
    logic accept;
    logic advance;
    logic pop;
    logic bypass;
    logic push;

    // in_ready is a function of registered count only: no path from
    // freeze/flush, and no pass-through when full even if a pop happens.
    assign queue_full  = (count_q == CNT_W'(DEPTH));
    assign queue_empty = (count_q == '0);

    assign fetch.in_ready = ~queue_full;

    assign accept  = fetch.in_valid & ~queue_full & ~flush;
    assign advance = ~freeze & ~flush;

    // With an empty queue an accepted input goes straight to the output
    // register and never occupies a queue slot.
    assign pop    = advance & ~queue_empty;
    assign bypass = advance &  queue_empty & accept;
    assign push   = accept  & ~bypass;

    // ------------------------------------------------------------------
    // Pointer / occupancy next-state
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            // A simultaneous pop and push leaves occupancy unchanged.
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Output register next-state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;

        if (flush) begin
            pc_d    = '0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (~freeze) begin
            if (~queue_empty) begin
                pc_d    = pc_mem[head_q];
                instr_d = instr_mem[head_q];
                valid_d = 1'b1;
            end else if (accept) begin
                pc_d    = fetch.PC_in;
                instr_d = fetch.Instruction_in;
                valid_d = 1'b1;
            end else begin
                // Nothing to hand over: present a bubble.
                pc_d    = '0;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // One write port per entry, selected by the tail pointer. A write that
    // lands during reset is harmless: the pointers are cleared in the same
    // edge, so the entry is treated as empty.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic wr_en;
            assign wr_en = push & (tail_q == PTR_W'(gi));

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    pc_mem[gi]    <= fetch.PC_in;
                    instr_mem[gi] <= fetch.Instruction_in;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign PC          = pc_q;
    assign Instruction = instr_q;
    assign out_valid   = valid_q;
    assign count       = count_q;

endmodule
